// File: rtl/fp_norm_pkg.sv
// Shared constants, shift-width helper and result classification for the
// FP add/sub normalization stage.
package fp_norm_pkg;

  localparam int unsigned MANT_W_DEF = 33;
  localparam int unsigned EXP_W_DEF  = 8;

  // Bits needed to hold a shift/leading-zero count in the range 0..w
  function automatic int unsigned shift_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  typedef enum logic [1:0] {
    RES_NORM  = 2'd0,
    RES_ZERO  = 2'd1,
    RES_UFLOW = 2'd2
  } res_class_e;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter built as a binary tree.
// The input is left-aligned into a power-of-two frame padded with zeros
// below, so a non-zero input counts correctly and an all-zero input
// reports W.
module fp_lzc #(
  parameter int unsigned W     = 33,
  parameter int unsigned OUT_W = 6
) (
  input  logic [W-1:0]     data_i,
  output logic [OUT_W-1:0] lzc_o
);

  localparam int unsigned LVLS = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned PW   = 1 << LVLS;

  // Each node holds (any-one-seen, zeros-above-first-one); pairs merge upward
  function automatic logic [OUT_W-1:0] lzc_tree(input logic [W-1:0] d);
    logic [PW-1:0]   pad;
    logic            vld [LVLS+1][PW];
    logic [LVLS-1:0] cnt [LVLS+1][PW];
    pad = '0;
    pad[PW-1 -: W] = d;
    for (int l = 0; l <= int'(LVLS); l++) begin
      for (int i = 0; i < int'(PW); i++) begin
        vld[l][i] = 1'b0;
        cnt[l][i] = '0;
      end
    end
    for (int i = 0; i < int'(PW); i++) begin
      vld[0][i] = pad[i];
    end
    for (int l = 1; l <= int'(LVLS); l++) begin
      for (int i = 0; i < int'(PW >> l); i++) begin
        if (vld[l-1][2*i+1]) begin
          vld[l][i] = 1'b1;
          cnt[l][i] = cnt[l-1][2*i+1];
        end else begin
          vld[l][i] = vld[l-1][2*i];
          cnt[l][i] = cnt[l-1][2*i] | LVLS'(1 << (l - 1));
        end
      end
    end
    return vld[LVLS][0] ? OUT_W'(cnt[LVLS][0]) : OUT_W'(W);
  endfunction

  // Leading-zero count of the current input
  always_comb begin
    lzc_o = lzc_tree(data_i);
  end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage normalization pipeline: S1 registers the operand with its
// leading-zero count, S2 shifts, adjusts the exponent and classifies the
// result (normal / zero / underflow). Valid/ready on both sides.
// Build option FP_NORM_DENORM_EN: gradual underflow (clamped shift,
// denormal mantissa) instead of flushing underflowed results to zero.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter int unsigned MANT_W = MANT_W_DEF,
  parameter int unsigned EXP_W  = EXP_W_DEF,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MANT_W-1:0]             in_sum,
  input  logic [EXP_W-1:0]              in_exp,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MANT_W-1:0]             out_mant,
  output logic [EXP_W-1:0]              out_exp,
  output logic [shift_w(MANT_W)-1:0]    out_shift,
  output logic                          out_zero,
  output logic                          out_uflow,
  output logic [TAG_W-1:0]              out_tag
);

  localparam int unsigned SHIFT_W = shift_w(MANT_W);
  localparam int unsigned CMP_W   = (EXP_W > SHIFT_W) ? EXP_W : SHIFT_W;

  logic                s1_valid_q, s1_valid_d;
  logic [MANT_W-1:0]   s1_sum_q,   s1_sum_d;
  logic [EXP_W-1:0]    s1_exp_q,   s1_exp_d;
  logic [TAG_W-1:0]    s1_tag_q,   s1_tag_d;
  logic [SHIFT_W-1:0]  s1_lzc_q,   s1_lzc_d;

  logic                out_valid_q, out_valid_d;
  logic [MANT_W-1:0]   out_mant_q,  out_mant_d;
  logic [EXP_W-1:0]    out_exp_q,   out_exp_d;
  logic [SHIFT_W-1:0]  out_shift_q, out_shift_d;
  logic                out_zero_q,  out_zero_d;
  logic                out_uflow_q, out_uflow_d;
  logic [TAG_W-1:0]    out_tag_q,   out_tag_d;

  logic [SHIFT_W-1:0]  lzc_c;
  logic                s2_adv_c;
  res_class_e          res_cls_c;
  logic [MANT_W-1:0]   mant_c;
  logic [EXP_W-1:0]    exp_c;
  logic [SHIFT_W-1:0]  shift_c;
  logic [CMP_W-1:0]    lzc_x_c, exp_x_c;

  fp_lzc #(
    .W     (MANT_W),
    .OUT_W (SHIFT_W)
  ) u_lzc (
    .data_i (in_sum),
    .lzc_o  (lzc_c)
  );

  // S2 datapath: classify the S1 operand and form the normalized result
  always_comb begin
    res_cls_c = RES_NORM;
    mant_c    = '0;
    exp_c     = '0;
    shift_c   = '0;
    lzc_x_c   = CMP_W'(s1_lzc_q);
    exp_x_c   = CMP_W'(s1_exp_q);
    if (s1_sum_q == '0) begin
      res_cls_c = RES_ZERO;
    end else if (lzc_x_c >= exp_x_c) begin
      res_cls_c = RES_UFLOW;
    end
    case (res_cls_c)
      RES_NORM: begin
        shift_c = s1_lzc_q;
        mant_c  = s1_sum_q << s1_lzc_q;
        exp_c   = EXP_W'(exp_x_c - lzc_x_c);
      end
      RES_UFLOW: begin
`ifdef FP_NORM_DENORM_EN
        // Largest shift that still leaves the exponent at the denormal floor
        shift_c = (s1_exp_q == '0) ? '0 : SHIFT_W'(exp_x_c - CMP_W'(1));
        mant_c  = s1_sum_q << shift_c;
`else
        shift_c = s1_lzc_q;
`endif
      end
      default: ;
    endcase
  end

  // Handshake and next-state for both pipeline stages
  always_comb begin
    s2_adv_c    = !out_valid_q || out_ready;
    in_ready    = !s1_valid_q || s2_adv_c;

    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    s1_exp_d    = s1_exp_q;
    s1_tag_d    = s1_tag_q;
    s1_lzc_d    = s1_lzc_q;
    out_valid_d = out_valid_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_shift_d = out_shift_q;
    out_zero_d  = out_zero_q;
    out_uflow_d = out_uflow_q;
    out_tag_d   = out_tag_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sum_d = in_sum;
        s1_exp_d = in_exp;
        s1_tag_d = in_tag;
        s1_lzc_d = lzc_c;
      end
    end

    if (s2_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_mant_d  = mant_c;
        out_exp_d   = exp_c;
        out_shift_d = shift_c;
        out_zero_d  = (res_cls_c == RES_ZERO);
        out_uflow_d = (res_cls_c == RES_UFLOW);
        out_tag_d   = s1_tag_q;
      end
    end
  end

  // Pipeline registers; reset drops every in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_exp_q    <= '0;
      s1_tag_q    <= '0;
      s1_lzc_q    <= '0;
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_shift_q <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_exp_q    <= s1_exp_d;
      s1_tag_q    <= s1_tag_d;
      s1_lzc_q    <= s1_lzc_d;
      out_valid_q <= out_valid_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_shift_q <= out_shift_d;
      out_zero_q  <= out_zero_d;
      out_uflow_q <= out_uflow_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_shift = out_shift_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;
  assign out_tag   = out_tag_q;

endmodule

// File: doc/fp_normalize_pipe.md
Name: fp_normalize_pipe

Overview:
- Parametrised, pipelined normalization stage for the FP add/sub datapath.
- Takes the raw mantissa sum (hidden bit plus GRS) and its pre-normalization exponent.
- Counts leading zeros and performs the full left shift in one block, not only a coarse 16-bit shift. Adjusts the exponent and flags zero and underflow.
- Sits between the mantissa adder and the rounding module. Uses a valid/ready handshake so the datapath can stall.

Parameters:
- MANT_W, 33, width of the mantissa sum including hidden bit and GRS bits.
- EXP_W, 8, width of the biased exponent.
- TAG_W, 4, width of the sideband tag carried alongside each operand (sign, op id, etc.).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- in_sum  in  MANT_W  mantissa sum; MSB is the weight-1 position for in_exp.
- in_exp  in  EXP_W  biased exponent associated with in_sum[MANT_W-1].
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_mant  out  MANT_W  normalized mantissa.
- out_exp  out  EXP_W  adjusted exponent.
- out_shift  out  SHIFT_W  applied left-shift amount; SHIFT_W = clog2(MANT_W+1).
- out_zero  out  1  input sum was all zeros.
- out_uflow  out  1  result exponent underflowed.
- out_tag  out  TAG_W  sideband of this beat.

Behaviour:
- Pipeline: two register stages.
  - S1 registers in_sum, in_exp, in_tag and lzc (leading-zero count of in_sum, range 0..MANT_W).
  - S2 performs the barrel left shift and exponent arithmetic, then registers all out_* signals.
- Latency: exactly 2 cycles from input acceptance (in_valid && in_ready) to out_valid, when out_ready is held high. Throughput is 1 beat per cycle.
- Handshake rules:
  - A beat transfers when valid && ready.
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv. This is combinational from out_ready, which is accepted.
  - out_* signals hold stable while out_valid && !out_ready.
  - Capacity is 2 beats: in_ready deasserts when both stages are full and out_ready is low.
- Normal case (in_sum != 0 and lzc < in_exp):
  - out_shift = lzc
  - out_mant = in_sum << lzc, so its MSB = 1
  - out_exp = in_exp - lzc
  - out_zero = 0, out_uflow = 0
- Zero case (in_sum == 0): out_mant = 0, out_exp = 0, out_shift = 0, out_zero = 1, out_uflow = 0.
- Underflow case (in_sum != 0 and lzc >= in_exp): out_uflow = 1. Output values depend on the optional feature below.
- Exponent arithmetic is unsigned EXP_W-bit. The underflow compare uses lzc zero-extended to max(EXP_W, SHIFT_W); no wrap-around is allowed.
- Reset:
  - s1_valid and out_valid clear to 0. in_ready reads 1 in the cycle after reset.
  - out_mant, out_exp, out_shift, out_zero, out_uflow and out_tag all reset to 0.
  - Reset mid-stream discards all in-flight beats with no output.
- Simultaneous events: if S2 drains while S1 is full and a new input arrives in the same cycle, all three moves occur with no bubble.

Optional Feature:
- Macro: FP_NORM_DENORM_EN.
- Defined (gradual underflow):
  - Shift is clamped to in_exp-1, or to 0 when in_exp = 0.
  - out_mant = in_sum << clamped shift; out_exp = 0; out_shift = clamped value; out_uflow = 1.
- Undefined (flush to zero): out_mant = 0, out_exp = 0, out_shift = lzc, out_uflow = 1, out_zero = 0.

Decomposition:
- Package fp_norm_pkg holds:
  - default MANT_W/EXP_W constants
  - a clog2-based SHIFT_W function
  - an enum/typedef for the result class (NORM, ZERO, UFLOW), used internally in S2
- One sub-module, fp_lzc: parametrised combinational leading-zero counter (width MANT_W, output SHIFT_W), built as a tree. It replaces the flat priority chain and is instantiated in S1.

Test Plan (MANT_W=33, EXP_W=8):
1. in_sum=33'h1_0000_0000, in_exp=130, out_ready=1 -> 2 cycles later: out_shift=0, out_exp=130, out_mant unchanged, flags 0.
2. in_sum=33'h0_0000_0080 (bit 7), in_exp=130 -> out_shift=25, out_exp=105, out_mant=33'h1_0000_0000.
3. in_sum=0, in_exp=90 -> out_zero=1, out_mant=0, out_exp=0, out_shift=0.
4. in_sum bit 27 only (lzc=5), in_exp=3:
   - without macro -> out_uflow=1, out_mant=0, out_exp=0, out_shift=5.
   - with FP_NORM_DENORM_EN -> out_shift=2, out_mant has bit 29 set, out_exp=0, out_uflow=1.
5. Back-pressure: 4 back-to-back beats, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted. On release, beats emerge in order, tags 0,1,2,3, and none are lost or duplicated.
6. Reset asserted while 2 beats are in flight -> next cycle out_valid=0, all outputs 0, in_ready=1. A beat sent after reset appears 2 cycles later.
